// File: rtl/osecpu_seq_core_if.sv
// osecpu_seq_core_if: instruction-memory fetch bus between the sequencer and instruction memory.
//   imem_req    core -> mem   fetch request, held high until imem_ack
//   imem_addr   core -> mem   fetch address (PC_W bits)
//   imem_rdata  mem  -> core  32-bit instruction word, valid while imem_ack=1
//   imem_ack    mem  -> core  1-cycle acknowledge, only meaningful while imem_req=1
interface osecpu_seq_core_if #(
   parameter int PC_W = 16
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            imem_ack;
   modport master (output imem_req, imem_addr, input imem_rdata, imem_ack);
   modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ack);
endinterface

// File: rtl/osecpu_seq_core.sv
// osecpu_seq_core: OSECPU fetch/execute sequencer with register file, ALU, DR and halt control.
//   clk_org  in   system clock, all state on posedge
//   reset    in   synchronous active-high reset
//   run      in   1: free-run, 0: wait in IDLE for step
//   step     in   one-cycle pulse while idle: execute one instruction
//   imem     --   master side of the req/ack instruction fetch bus
//   pc       out  program counter
//   dr       out  debug register written by CPDR
//   halted   out  high after END until reset
//   illegal  out  sticky flag: an unknown opcode was executed
//   state    out  FSM state: 0 IDLE, 1 FETCH, 2 EXEC, 3 HALT
module osecpu_seq_core #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 16,
   parameter int NREG   = 64
) (
   input  logic               clk_org,
   input  logic               reset,
   input  logic               run,
   input  logic               step,
   osecpu_seq_core_if.master  imem,
   output logic [PC_W-1:0]    pc,
   output logic [DATA_W-1:0]  dr,
   output logic               halted,
   output logic               illegal,
   output logic [1:0]         state
);
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2, HALT = 2'd3} state_t;
   localparam int OFF_W = PC_W > 16 ? PC_W : 16;
   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0] dr_q, dr_d;
   logic              illegal_q, illegal_d;
   logic [31:0]       instr_q, instr_d;
   logic [DATA_W-1:0] rf_q [NREG];
   logic [DATA_W-1:0] rf_d [NREG];
   logic [7:0]        op;
   logic [5:0]        o0, o1, o2;
   logic [DATA_W-1:0] r0, r1, r2, sext, wdata;
   logic [OFF_W-1:0]  off;
   logic              we, known;
   function automatic logic [DATA_W-1:0] rd(input logic [5:0] i);
      return (int'(i) < NREG) ? rf_q[i] : '0;
   endfunction
   assign op    = instr_q[31:24];
   assign o0    = instr_q[23:18];
   assign o1    = instr_q[17:12];
   assign o2    = instr_q[11:6];
   assign r0    = rd(o0);
   assign r1    = rd(o1);
   assign r2    = rd(o2);
   assign sext  = DATA_W'($signed(instr_q[15:0]));
   assign off   = OFF_W'($signed(instr_q[15:0]));
   assign wdata = op == 8'h02 ? sext : op == 8'hD2 ? r1 : op == 8'h14 ? r1 + r2 : r1 - r2;
   assign we    = op inside {8'h02, 8'hD2, 8'h14, 8'h15};
   assign known = we || op inside {8'hD3, 8'h04, 8'hF0};
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      dr_d      = dr_q;
      illegal_d = illegal_q;
      instr_d   = instr_q;
      rf_d      = rf_q;
      case (state_q)
         IDLE:  state_d = (run || step) ? FETCH : IDLE;
         FETCH: begin
            instr_d = imem.imem_ack ? imem.imem_rdata : instr_q;
            state_d = imem.imem_ack ? EXEC : FETCH;
         end
         EXEC: begin
            state_d = op == 8'hF0 ? HALT : run ? FETCH : IDLE;
            pc_d    = op == 8'hF0 ? pc_q
                    : (op == 8'h04 && r0 != '0) ? pc_q + PC_W'(1) + off[PC_W-1:0]
                    : pc_q + PC_W'(1);
            dr_d      = op == 8'hD3 ? r1 : dr_q;
            illegal_d = illegal_q | ~known;
            // writes to unimplemented register indices are silently dropped
            if (we && int'(o0) < NREG) rf_d[o0] = wdata;
         end
         default: state_d = HALT;
      endcase
   end
   always_ff @(posedge clk_org) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= '0;
         dr_q      <= '0;
         illegal_q <= 1'b0;
         instr_q   <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         dr_q      <= dr_d;
         illegal_q <= illegal_d;
         instr_q   <= instr_d;
         rf_q      <= rf_d;
      end
   end
   // the request is a pure function of state, so reset withdraws it on the next cycle
   assign imem.imem_req  = state_q == FETCH;
   assign imem.imem_addr = pc_q;
   assign pc      = pc_q;
   assign dr      = dr_q;
   assign halted  = state_q == HALT;
   assign illegal = illegal_q;
   assign state   = state_q;
endmodule

// File: tb/tb_osecpu_seq_core.sv
// tb_osecpu_seq_core: directed programs against an instruction-level model of the sequencer.
module tb_osecpu_seq_core;
   logic        clk_org = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        step = 1'b0;
   logic [15:0] pc;
   logic [31:0] dr;
   logic        halted, illegal;
   logic [1:0]  state;
   int          checks = 0, errors = 0;
   osecpu_seq_core_if #(.PC_W(16)) bus();
   osecpu_seq_core #(.DATA_W(32), .PC_W(16), .NREG(64)) dut (
      .clk_org(clk_org), .reset(reset), .run(run), .step(step), .imem(bus),
      .pc(pc), .dr(dr), .halted(halted), .illegal(illegal), .state(state)
   );
   always #5 clk_org = ~clk_org;
   logic [31:0] mem [64];
   logic [31:0] m_r [64];
   logic [15:0] m_pc;
   logic [31:0] m_dr;
   logic        m_halt, m_ill;
   int          retired, taken;
   logic        pend, take, cmp_en = 1'b0;
   logic [31:0] pinstr, tword;
   logic        resp_en = 1'b1, busy = 1'b0;
   int          min_dly = 0, max_dly = 0, dly = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [31:0] fr(input logic [7:0] op, input int a, input int b, input int c);
      return {op, 6'(a), 6'(b), 6'(c), 6'd0};
   endfunction
   function automatic logic [31:0] fi(input logic [7:0] op, input int a, input logic [15:0] imm);
      return {op, 6'(a), 2'b00, imm};
   endfunction
   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_r[i] = '0;
      m_pc = '0; m_dr = '0; m_halt = 1'b0; m_ill = 1'b0;
      retired = 0; taken = 0; pend = 1'b0;
   endtask
   task automatic model_exec(input logic [31:0] w);
      logic [7:0] op;
      int a, b, c, off;
      op = w[31:24]; a = int'(w[23:18]); b = int'(w[17:12]); c = int'(w[11:6]);
      off = int'($signed(w[15:0]));
      retired++;
      if (op == 8'hF0) m_halt = 1'b1;
      else begin
         m_pc = m_pc + 16'd1;
         case (op)
            8'h02: m_r[a] = 32'(off);
            8'hD2: m_r[a] = m_r[b];
            8'h14: m_r[a] = m_r[b] + m_r[c];
            8'h15: m_r[a] = m_r[b] - m_r[c];
            8'hD3: m_dr = m_r[b];
            8'h04: if (m_r[a] != 0) begin m_pc = 16'(int'(m_pc) + off); taken++; end
            default: m_ill = 1'b1;
         endcase
      end
   endtask
   // instruction memory: acks after a random wait chosen per request
   initial begin
      bus.imem_ack = 1'b0; bus.imem_rdata = '0; take = 1'b0;
      forever begin
         @(negedge clk_org);
         if (resp_en) begin
            bus.imem_ack = 1'b0; take = 1'b0;
            if (bus.imem_req && !reset) begin
               if (!busy) begin busy = 1'b1; dly = $urandom_range(max_dly, min_dly); end
               if (dly == 0) begin
                  bus.imem_ack = 1'b1; bus.imem_rdata = mem[bus.imem_addr[5:0]];
                  take = 1'b1; tword = mem[bus.imem_addr[5:0]]; busy = 1'b0;
               end else dly--;
            end else busy = 1'b0;
         end
      end
   end
   // model: an acked word executes on the clock edge after the one that accepted it
   initial begin
      model_reset();
      forever begin
         @(posedge clk_org);
         if (reset) model_reset();
         else begin
            if (pend) begin model_exec(pinstr); pend = 1'b0; end
            if (take) begin pend = 1'b1; pinstr = tword; end
         end
      end
   end
   initial begin
      forever begin
         @(negedge clk_org);
         if (cmp_en) begin
            chk("pc", pc, m_pc);
            chk("dr", dr, m_dr);
            chk("halted", halted, m_halt);
            chk("illegal", illegal, m_ill);
            if (m_halt) chk("req_in_halt", bus.imem_req, 1'b0);
         end
      end
   end
   task automatic do_reset();
      reset = 1'b1; run = 1'b0; step = 1'b0;
      repeat (2) @(negedge clk_org);
      reset = 1'b0;
   endtask
   task automatic clr_mem();
      for (int i = 0; i < 64; i++) mem[i] = 32'hF000_0000;
   endtask
   task automatic run_until_halt(output int cyc);
      run = 1'b1; cyc = 0;
      while (!halted && cyc < 600) begin @(negedge clk_org); cyc++; end
      chk("halt_reached", halted, 1'b1);
      run = 1'b0;
   endtask
   task automatic wait_state(input logic [1:0] s, input string name);
      int n = 0;
      while (state != s && n < 40) begin @(negedge clk_org); n++; end
      chk(name, state, s);
   endtask
   int cyc;
   initial begin
      clr_mem();
      do_reset();
      cmp_en = 1'b1;
      chk("rst_pc", pc, 0); chk("rst_dr", dr, 0); chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal, 0); chk("rst_req", bus.imem_req, 0); chk("rst_state", state, 0);
      // add program, zero-latency memory: 2 cycles per instruction plus one IDLE cycle
      mem[0] = fi(8'h02, 1, 16'h0005); mem[1] = fi(8'h02, 2, 16'hFFFD);
      mem[2] = fr(8'h14, 3, 1, 2);     mem[3] = fr(8'hD3, 0, 3, 0); mem[4] = fr(8'hF0, 0, 0, 0);
      run_until_halt(cyc);
      chk("add_cycles", cyc, 11); chk("add_dr", dr, 2); chk("add_pc", pc, 4);
      chk("add_model_dr", m_dr, 2); chk("add_model_ret", retired, 5);
      repeat (3) @(negedge clk_org);
      chk("halt_absorb_state", state, 3);
      // subtract with random latency
      do_reset(); clr_mem(); max_dly = 3;
      mem[0] = fi(8'h02, 1, 16'h0005); mem[1] = fi(8'h02, 2, 16'hFFFD);
      mem[2] = fr(8'h15, 4, 2, 1);     mem[3] = fr(8'hD3, 0, 4, 0);
      run_until_halt(cyc);
      chk("sub_dr", dr, 32'hFFFF_FFF8); chk("sub_model_dr", m_dr, 32'hFFFF_FFF8);
      // countdown loop with a backward conditional branch
      do_reset(); clr_mem(); max_dly = 2;
      mem[0] = fi(8'h02, 1, 16'd3); mem[1] = fi(8'h02, 2, 16'd1);
      mem[2] = fr(8'h15, 1, 1, 2);  mem[3] = fi(8'h04, 1, 16'hFFFE);
      mem[4] = fr(8'hD3, 0, 2, 0);
      run_until_halt(cyc);
      chk("loop_dr", dr, 1); chk("loop_pc", pc, 5);
      chk("loop_taken", taken, 2); chk("loop_retired", retired, 10);
      // single-step with run low
      do_reset(); clr_mem(); max_dly = 5;
      mem[0] = fi(8'h02, 1, 16'd7); mem[1] = fi(8'h02, 2, 16'd9);
      mem[2] = fr(8'h14, 3, 1, 2);  mem[3] = fr(8'hD3, 0, 3, 0);
      for (int k = 0; k < 4; k++) begin
         step = 1'b1; @(negedge clk_org); step = 1'b0;
         wait_state(2'd0, "step_idle");
         chk("step_retired", retired, k + 1); chk("step_pc", pc, k + 1);
      end
      repeat (5) @(negedge clk_org);
      chk("step_hold_pc", pc, 4); chk("step_dr", dr, 16); chk("step_state", state, 0);
      // unknown opcode leaves registers and dr alone
      do_reset(); clr_mem(); max_dly = 1;
      mem[0] = fi(8'h02, 1, 16'd6); mem[1] = fr(8'hD3, 0, 1, 0);
      mem[2] = fr(8'h77, 1, 2, 3);  mem[3] = fr(8'hD3, 0, 1, 0);
      run_until_halt(cyc);
      chk("ill_flag", illegal, 1); chk("ill_dr", dr, 6); chk("ill_pc", pc, 4);
      do_reset();
      chk("ill_clr", illegal, 0); chk("ill_clr_pc", pc, 0);
      // run dropped while a fetch is outstanding
      clr_mem(); min_dly = 3; max_dly = 3;
      mem[0] = fi(8'h02, 1, 16'd1);
      run = 1'b1;
      wait_state(2'd1, "drop_fetch");
      run = 1'b0;
      chk("drop_req_held", bus.imem_req, 1);
      wait_state(2'd0, "drop_idle");
      repeat (3) @(negedge clk_org);
      chk("drop_retired", retired, 1); chk("drop_pc", pc, 1); chk("drop_state", state, 0);
      // reset during fetch, ack arriving one cycle late
      min_dly = 0; max_dly = 0;
      do_reset(); resp_en = 1'b0;
      run = 1'b1;
      wait_state(2'd1, "rf_fetch");
      reset = 1'b1; run = 1'b0;
      @(negedge clk_org);
      chk("rf_req", bus.imem_req, 0); chk("rf_pc", pc, 0);
      reset = 1'b0; bus.imem_ack = 1'b1; bus.imem_rdata = fi(8'h02, 1, 16'd1);
      @(negedge clk_org);
      bus.imem_ack = 1'b0;
      repeat (2) @(negedge clk_org);
      chk("rf_state", state, 0); chk("rf_pc_after", pc, 0);
      chk("rf_req_after", bus.imem_req, 0); chk("rf_retired", retired, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
